// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receive path: parity modes,
// receiver state encoding and timer sizing.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_e;

  // The timer must hold CLKS_PER_BIT-1; guard degenerate small values.
  function automatic int timer_width(input int clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an idle-high asynchronous line; presets to 1 so
// reset never looks like a start edge.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised input, mid-bit sampling, false-start
// rejection, parity/framing flags and break recovery.
//
//   state     | meaning
//   IDLE      | line idle, waiting for rx_s low
//   START     | timing to start-bit centre, rejecting glitches
//   DATA      | sampling DATA_BITS data bits, LSB first
//   PARITY    | sampling the parity bit
//   STOP      | sampling STOP_BITS stop bits, then publishing the frame
//   WAIT_IDLE | framing error / break, waiting for the line to return high
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1736,
  parameter int DATA_BITS    = 7,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = timer_width(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] HALF_TC   = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_TC    = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  logic rx_s;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_in),
    .q     (rx_s)
  );

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_acc_q, par_acc_d;
  logic                 frm_acc_q, frm_acc_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;

  logic bit_tc;
  logic frm_now;
  logic par_xor;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + TW'(1);
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_acc_d    = par_acc_q;
    frm_acc_d    = frm_acc_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    bit_tc       = (timer_q == BIT_TC);
    frm_now      = frm_acc_q | ~rx_s;
    par_xor      = (^shift_q) ^ rx_s;

    case (state_q)
      IDLE: begin
        timer_d   = '0;
        bit_cnt_d = '0;
        par_acc_d = 1'b0;
        frm_acc_d = 1'b0;
        if (!rx_s) state_d = START;
      end

      START: begin
        if (timer_q == HALF_TC) begin
          timer_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end

      DATA: begin
        if (bit_tc) begin
          timer_d = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end

      PARITY: begin
        if (bit_tc) begin
          timer_d   = '0;
          par_acc_d = (PARITY_MODE == PAR_ODD) ? ~par_xor : par_xor;
          state_d   = STOP;
        end
      end

      STOP: begin
        if (bit_tc) begin
          timer_d   = '0;
          frm_acc_d = frm_now;
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d    = '0;
            data_valid_d = 1'b1;
            data_out_d   = shift_q;
            parity_err_d = (PARITY_MODE != PAR_NONE) && par_acc_q;
            frame_err_d  = frm_now;
            // Leaving to IDLE here lets a start edge in the last half stop bit through.
            state_d      = frm_now ? WAIT_IDLE : IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end

      WAIT_IDLE: begin
        timer_d = '0;
        if (rx_s) state_d = IDLE;
      end

      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_acc_q    <= 1'b0;
      frm_acc_q    <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_acc_q    <= par_acc_d;
      frm_acc_q    <= frm_acc_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed and randomised bench for uart_rx_param: two instances (even/1 stop
// and odd/2 stop) driven by a bit-level line model and a frame-level reference.
module tb_uart_rx_param;

  localparam int CPB = 16;
  localparam int DB  = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;

  logic [DB-1:0] data_a, data_b;
  logic dv_a, dv_b, perr_a, perr_b, ferr_a, ferr_b, busy_a, busy_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_MODE(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_a), .data_out(data_a), .data_valid(dv_a),
    .parity_err(perr_a), .frame_err(ferr_a), .busy(busy_a)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_MODE(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_b), .data_out(data_b), .data_valid(dv_b),
    .parity_err(perr_b), .frame_err(ferr_b), .busy(busy_b)
  );

  // Every high cycle of data_valid is captured, so a stretched pulse shows up as an extra entry.
  logic [8:0] q_a[$];
  logic [8:0] q_b[$];

  always @(negedge clk) begin
    if (dv_a) q_a.push_back({perr_a, ferr_a, data_a});
    if (dv_b) q_b.push_back({perr_b, ferr_b, data_b});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int which, input logic val, input int cycles);
    if (which == 0) rx_a = val;
    else            rx_b = val;
    repeat (cycles) @(negedge clk);
  endtask

  // Reference: correct parity bit from the population count of the word.
  function automatic logic good_parity(input int which, input logic [DB-1:0] word);
    int ones;
    ones = $countones(word);
    return (which == 0) ? logic'(ones % 2) : logic'(1 - (ones % 2));
  endfunction

  task automatic send_frame(input int which, input logic [DB-1:0] word, input logic par_bit,
                            input logic [1:0] stops, output logic busy_mid);
    int nstop;
    nstop = (which == 0) ? 1 : 2;
    hold(which, 1'b0, CPB);
    for (int i = 0; i < DB; i++) hold(which, word[i], CPB);
    busy_mid = (which == 0) ? busy_a : busy_b;
    hold(which, par_bit, CPB);
    for (int s = 0; s < nstop; s++) hold(which, stops[s], CPB);
    if (which == 0) rx_a = 1'b1;
    else            rx_b = 1'b1;
  endtask

  task automatic send_good(input int which, input logic [DB-1:0] word);
    logic bm;
    send_frame(which, word, good_parity(which, word), 2'b11, bm);
  endtask

  task automatic expect_frame(input int which, input string tag, input logic [DB-1:0] word,
                              input logic perr, input logic ferr);
    int n;
    int sz;
    logic [8:0] e;
    n = 0;
    sz = (which == 0) ? q_a.size() : q_b.size();
    while (sz == 0 && n < 3 * CPB) begin
      @(negedge clk);
      n++;
      sz = (which == 0) ? q_a.size() : q_b.size();
    end
    check({tag, " valid"}, 16'(sz != 0), 16'd1);
    if (sz != 0) begin
      e = (which == 0) ? q_a.pop_front() : q_b.pop_front();
      check({tag, " data"}, 16'(e[6:0]), 16'(word));
      check({tag, " perr"}, 16'(e[8]), 16'(perr));
      check({tag, " ferr"}, 16'(e[7]), 16'(ferr));
    end
  endtask

  initial begin
    logic bm;
    logic [DB-1:0] w, held_d;
    logic pb, held_p, held_f;
    logic [1:0] st;

    repeat (3) @(negedge clk);
    check("rst data_a", 16'(data_a), 16'd0);
    check("rst flags_a", 16'({dv_a, perr_a, ferr_a, busy_a}), 16'd0);
    check("rst data_b", 16'(data_b), 16'd0);
    check("rst flags_b", 16'({dv_b, perr_b, ferr_b, busy_b}), 16'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Good frame 7'h55
    send_frame(0, 7'h55, 1'b0, 2'b11, bm);
    check("t1 busy mid", 16'(bm), 16'd1);
    expect_frame(0, "t1", 7'h55, 1'b0, 1'b0);
    check("t1 busy after", 16'(busy_a), 16'd0);
    check("t1 single pulse", 16'(q_a.size()), 16'd0);

    // Wrong parity on 7'h3A, then a good frame clears the flag
    send_frame(0, 7'h3A, 1'b1, 2'b11, bm);
    expect_frame(0, "t2 bad", 7'h3A, 1'b1, 1'b0);
    check("t2 perr held", 16'(perr_a), 16'd1);
    send_good(0, 7'h01);
    expect_frame(0, "t2 good", 7'h01, 1'b0, 1'b0);
    check("t2 perr cleared", 16'(perr_a), 16'd0);

    // Start glitch of 5 clocks
    held_d = data_a; held_p = perr_a; held_f = ferr_a;
    hold(0, 1'b0, 5);
    check("glitch busy", 16'(busy_a), 16'd1);
    hold(0, 1'b1, 2 * CPB);
    check("glitch idle", 16'(busy_a), 16'd0);
    check("glitch no dv", 16'(q_a.size()), 16'd0);
    check("glitch data", 16'(data_a), 16'(held_d));
    check("glitch flags", 16'({perr_a, ferr_a}), 16'({held_p, held_f}));

    // Framing error followed by a break
    send_frame(0, 7'h12, good_parity(0, 7'h12), 2'b00, bm);
    rx_a = 1'b0;
    expect_frame(0, "brk", 7'h12, 1'b0, 1'b1);
    hold(0, 1'b0, 3 * CPB);
    check("brk wait busy", 16'(busy_a), 16'd1);
    check("brk no extra dv", 16'(q_a.size()), 16'd0);
    check("brk ferr held", 16'(ferr_a), 16'd1);
    hold(0, 1'b1, CPB);
    check("brk recovered", 16'(busy_a), 16'd0);
    send_good(0, 7'h2B);
    expect_frame(0, "brk next", 7'h2B, 1'b0, 1'b0);
    check("brk ferr cleared", 16'(ferr_a), 16'd0);

    // Back-to-back frames, no idle gap
    send_good(0, 7'h01);
    send_good(0, 7'h7F);
    expect_frame(0, "b2b a0", 7'h01, 1'b0, 1'b0);
    expect_frame(0, "b2b a1", 7'h7F, 1'b0, 1'b0);
    send_good(1, 7'h01);
    send_good(1, 7'h7F);
    expect_frame(1, "b2b b0", 7'h01, 1'b0, 1'b0);
    expect_frame(1, "b2b b1", 7'h7F, 1'b0, 1'b0);
    repeat (CPB) @(negedge clk);
    check("b2b a count", 16'(q_a.size()), 16'd0);
    check("b2b b count", 16'(q_b.size()), 16'd0);

    // Randomised frames against the frame-level reference
    for (int k = 0; k < 8; k++) begin
      int which;
      which = k % 2;
      w  = DB'($urandom_range(0, 127));
      pb = logic'($urandom_range(0, 1));
      st = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) st = 2'b11;
      if (which == 0) st[1] = 1'b1;
      send_frame(which, w, pb, st, bm);
      expect_frame(which, "rand", w, pb != good_parity(which, w),
                   (which == 0) ? ~st[0] : ~(st[0] & st[1]));
      hold(which, 1'b1, CPB);
    end

    // Reset in the middle of data bit 3 of 7'h66
    w = 7'h66;
    hold(0, 1'b0, CPB);
    for (int i = 0; i < 3; i++) hold(0, w[i], CPB);
    hold(0, w[3], CPB / 2);
    check("rst mid busy", 16'(busy_a), 16'd1);
    rst_n = 1'b0;
    #1;
    check("rst mid data", 16'(data_a), 16'd0);
    check("rst mid flags", 16'({dv_a, perr_a, ferr_a, busy_a}), 16'd0);
    @(negedge clk);
    rx_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_good(0, 7'h19);
    expect_frame(0, "post rst", 7'h19, 1'b0, 1'b0);
    repeat (CPB) @(negedge clk);
    check("end q_a empty", 16'(q_a.size()), 16'd0);
    check("end q_b empty", 16'(q_b.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
